apple_spawner: RTL

//  Owns the apple in the snake game. Holds the apple grid position, detects head/apple

---
 rtl/apple_spawner.sv | 112 +++++++++++
 1 files changed

// File: rtl/apple_spawner.sv
// Apple owner for the snake game: holds the apple cell, detects the head eating it,
// and respawns the apple at a pseudo-random free cell with a bounded fallback.
//
// state  | meaning
// PLACE  | no apple visible; try one LFSR candidate per cycle, fallback on last try
// ACTIVE | apple visible; watch head moves for an eat
module apple_spawner #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          XW        = 5,
    parameter int          YW        = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 15
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          clear_i,
    input  logic          head_valid_i,
    input  logic [XW-1:0] head_x_i,
    input  logic [YW-1:0] head_y_i,
    output logic [XW-1:0] apple_x_o,
    output logic [YW-1:0] apple_y_o,
    output logic          apple_valid_o,
    output logic          apple_colline
);

    typedef enum logic {PLACE, ACTIVE} state_t;

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [XW:0] GW       = (XW+1)'(GRID_W);
    localparam logic [XW:0] HALF_W   = (XW+1)'(GRID_W / 2);
    localparam logic [YW:0] GH       = (YW+1)'(GRID_H);

    state_t        state;
    logic [TW-1:0] tries;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          cand_ok;
    logic [XW:0]   fb_sum;
    logic [XW:0]   fb_mod;
    logic [XW-1:0] fb_x;
    logic          eat;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        cx        = lfsr[XW-1:0];
        cy        = lfsr[XW+YW-1:XW];
        cand_ok   = ({1'b0, cx} < GW) && ({1'b0, cy} < GH) &&
                    !((cx == head_x_i) && (cy == head_y_i));
        // sum kept one bit wider so a head beyond GRID_W/2 cannot wrap before the modulo
        fb_sum    = {1'b0, head_x_i} + HALF_W;
        fb_mod    = fb_sum % GW;
        fb_x      = fb_mod[XW-1:0];
        eat       = head_valid_i && (head_x_i == apple_x_o) && (head_y_i == apple_y_o);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= PLACE;
            tries         <= '0;
            lfsr          <= SEED;
            apple_x_o     <= '0;
            apple_y_o     <= '0;
            apple_valid_o <= 1'b0;
            apple_colline <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (clear_i) begin
                state         <= PLACE;
                tries         <= '0;
                apple_valid_o <= 1'b0;
                apple_colline <= 1'b0;
            end else begin
                case (state)
                    PLACE: begin
                        apple_colline <= 1'b0;
                        if (cand_ok) begin
                            apple_x_o     <= cx;
                            apple_y_o     <= cy;
                            apple_valid_o <= 1'b1;
                            tries         <= '0;
                            state         <= ACTIVE;
                        end else if (tries == TRY_LAST) begin
                            apple_x_o     <= fb_x;
                            apple_y_o     <= head_y_i;
                            apple_valid_o <= 1'b1;
                            tries         <= '0;
                            state         <= ACTIVE;
                        end else begin
                            tries <= tries + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (eat) begin
                            apple_colline <= 1'b1;
                            apple_valid_o <= 1'b0;
                            state         <= PLACE;
                        end else begin
                            apple_colline <= 1'b0;
                        end
                    end
                    default: state <= PLACE;
                endcase
            end
        end
    end

endmodule
